pwm_array: RTL

PWM_ARRAY -- requirements
Module: pwm_array

---
 rtl/pwm_pkg.sv | 32 +++
 rtl/pwm_chan.sv | 133 +++++++++++++
 rtl/pwm_array.sv | 109 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM array: channel modes, register word offsets,
// the global block index and a byte-enable merge helper.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam int GLOBAL_BLK = 0;

  // Global block words
  localparam logic [1:0] W_ENB       = 2'd0;
  localparam logic [1:0] W_INTR_STAT = 2'd1;
  localparam logic [1:0] W_INTR_MASK = 2'd2;
  localparam logic [1:0] W_INFO      = 2'd3;

  // Channel block words
  localparam logic [1:0] W_CFG    = 2'd0;
  localparam logic [1:0] W_PERIOD = 2'd1;
  localparam logic [1:0] W_DUTY   = 2'd2;
  localparam logic [1:0] W_COUNT  = 2'd3;

  function automatic logic [15:0] merge_be(input logic [15:0] old_val,
                                           input logic [15:0] new_val,
                                           input logic [1:0]  be);
    merge_be = old_val;
    if (be[0]) merge_be[7:0]  = new_val[7:0];
    if (be[1]) merge_be[15:8] = new_val[15:8];
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: config and shadow registers, prescaler, edge/center
// counter and the registered waveform output.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        mclk,
  input  logic        h_reset,
  input  logic        enb,
  input  logic        wr_en,
  input  logic [1:0]  word,
  input  logic [15:0] wdata,
  input  logic [1:0]  be,
  output logic [31:0] rdata,
  output logic        period_end,
  output logic        oneshot_clr,
  output logic        wfm
);

  logic [7:0]       presc;
  logic [7:0]       pcnt;
  logic             oneshot;
  logic             pol;
  pwm_mode_e        mode;
  logic [CNT_W-1:0] period_s;
  logic [CNT_W-1:0] duty_s;
  logic [CNT_W-1:0] period_a;
  logic [CNT_W-1:0] duty_a;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             dir_down;
  logic             dir_nxt;
  logic             tick;

  // In center mode a period of 1 turns around at the top and lands on 0 in
  // the same step, so the up branch can also produce the period end.
  always_comb begin
    tick       = enb && (pcnt == presc);
    count_nxt  = count;
    dir_nxt    = dir_down;
    period_end = 1'b0;
    if (tick) begin
      if (mode == PWM_EDGE) begin
        if (count >= period_a) begin
          count_nxt  = '0;
          period_end = 1'b1;
        end else begin
          count_nxt = count + 1'b1;
        end
      end else if (!dir_down) begin
        if (count < period_a) begin
          count_nxt = count + 1'b1;
        end else if (count == '0) begin
          period_end = 1'b1;
        end else begin
          count_nxt = count - 1'b1;
          if (count == CNT_W'(1)) period_end = 1'b1;
          else                    dir_nxt    = 1'b1;
        end
      end else begin
        count_nxt = count - 1'b1;
        if (count == CNT_W'(1)) begin
          period_end = 1'b1;
          dir_nxt    = 1'b0;
        end
      end
    end
  end

  assign oneshot_clr = period_end & oneshot;

  always_comb begin
    rdata = '0;
    case (word)
      W_CFG:    rdata = {16'b0, presc, 5'b0, oneshot, pol, mode};
      W_PERIOD: rdata = 32'(period_s);
      W_DUTY:   rdata = 32'(duty_s);
      default:  rdata = 32'(count);
    endcase
  end

  always_ff @(posedge mclk or posedge h_reset) begin
    if (h_reset) begin
      presc    <= '0;
      oneshot  <= 1'b0;
      pol      <= 1'b0;
      mode     <= PWM_EDGE;
      period_s <= '0;
      duty_s   <= '0;
      period_a <= '0;
      duty_a   <= '0;
      pcnt     <= '0;
      count    <= '0;
      dir_down <= 1'b0;
      wfm      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (word)
          W_CFG: begin
            if (be[1]) presc <= wdata[15:8];
            if (be[0]) begin
              oneshot <= wdata[2];
              pol     <= wdata[1];
              mode    <= pwm_mode_e'(wdata[0]);
            end
          end
          W_PERIOD: period_s <= CNT_W'(merge_be(16'(period_s), wdata, be));
          W_DUTY:   duty_s   <= CNT_W'(merge_be(16'(duty_s), wdata, be));
          default:  ;
        endcase
      end
      // Shadows flow straight into the active set while the channel is idle.
      if (!enb) begin
        pcnt     <= '0;
        count    <= '0;
        dir_down <= 1'b0;
        period_a <= period_s;
        duty_a   <= duty_s;
      end else begin
        pcnt     <= tick ? '0 : pcnt + 8'd1;
        count    <= count_nxt;
        dir_down <= dir_nxt;
        if (period_end) begin
          period_a <= period_s;
          duty_a   <= duty_s;
        end
      end
      wfm <= enb ? ((count < duty_a) ^ pol) : pol;
    end
  end

endmodule

// File: rtl/pwm_array.sv
// PWM array top: register decode, global enable/interrupt registers, read
// mux, single-cycle ack and NUM_CH channel instances.
module pwm_array
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              mclk,
  input  logic              h_reset,
  input  logic              reg_cs,
  input  logic              reg_wr,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_wdata,
  input  logic [3:0]        reg_be,
  output logic [31:0]       reg_rdata,
  output logic              reg_ack,
  output logic [NUM_CH-1:0] pwm_wfm,
  output logic              pwm_intr
);

  localparam int BLK_W = ADDR_W - 2;

  logic              access;
  logic              glb_wr;
  logic [BLK_W-1:0]  blk;
  logic [1:0]        word;
  logic [NUM_CH-1:0] enb;
  logic [NUM_CH-1:0] enb_nxt;
  logic [NUM_CH-1:0] intr_stat;
  logic [NUM_CH-1:0] intr_mask;
  logic [NUM_CH-1:0] w1c;
  logic [NUM_CH-1:0] chan_wr;
  logic [NUM_CH-1:0] chan_pend;
  logic [NUM_CH-1:0] chan_clr;
  logic [31:0]       chan_rd [NUM_CH];
  logic [31:0]       rd_mux;
  logic              unused_bits;

  assign access      = reg_cs & ~reg_ack;
  assign blk         = reg_addr[ADDR_W-1:2];
  assign word        = reg_addr[1:0];
  assign glb_wr      = access & reg_wr & (blk == BLK_W'(GLOBAL_BLK));
  assign unused_bits = ^{reg_wdata[31:16], reg_be[3:2]};

  generate
    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
      assign chan_wr[n] = access & reg_wr & (blk == BLK_W'(n + 1));
      pwm_chan #(.CNT_W(CNT_W)) u_chan (
        .mclk        (mclk),
        .h_reset     (h_reset),
        .enb         (enb[n]),
        .wr_en       (chan_wr[n]),
        .word        (word),
        .wdata       (reg_wdata[15:0]),
        .be          (reg_be[1:0]),
        .rdata       (chan_rd[n]),
        .period_end  (chan_pend[n]),
        .oneshot_clr (chan_clr[n]),
        .wfm         (pwm_wfm[n])
      );
    end
  endgenerate

  // Hardware one-shot clear and interrupt set both take priority over software.
  always_comb begin
    enb_nxt = enb;
    if (glb_wr && word == W_ENB && reg_be[0]) enb_nxt = reg_wdata[NUM_CH-1:0];
    enb_nxt = enb_nxt & ~chan_clr;
    w1c = '0;
    if (glb_wr && word == W_INTR_STAT && reg_be[0]) w1c = reg_wdata[NUM_CH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    if (blk == BLK_W'(GLOBAL_BLK)) begin
      case (word)
        W_ENB:       rd_mux = 32'(enb);
        W_INTR_STAT: rd_mux = 32'(intr_stat);
        W_INTR_MASK: rd_mux = 32'(intr_mask);
        default:     rd_mux = {12'b0, 4'(NUM_CH), 11'b0, 5'(CNT_W)};
      endcase
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (blk == BLK_W'(n + 1)) rd_mux = chan_rd[n];
      end
    end
  end

  always_ff @(posedge mclk or posedge h_reset) begin
    if (h_reset) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
      enb       <= '0;
      intr_stat <= '0;
      intr_mask <= '0;
      pwm_intr  <= 1'b0;
    end else begin
      reg_ack   <= access;
      reg_rdata <= access ? rd_mux : '0;
      enb       <= enb_nxt;
      intr_stat <= (intr_stat & ~w1c) | chan_pend;
      if (glb_wr && word == W_INTR_MASK && reg_be[0]) intr_mask <= reg_wdata[NUM_CH-1:0];
      pwm_intr  <= |(intr_stat & intr_mask);
    end
  end

endmodule
